// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: one-hot T1..T6 ring plus combinational control-word decode.
// Optional feature macro: SHORT_CYCLE_EN (ring returns to T1 after an instruction's last active state).
module controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic [3:0] opcode,
  output logic       pc_increment,
  output logic       pc_output,
  output logic       mar_load,
  output logic       ram_output,
  output logic       ir_load,
  output logic       ir_output,
  output logic       a_load,
  output logic       a_output,
  output logic       alu_subtract,
  output logic       alu_output,
  output logic       b_load,
  output logic       out_load,
  output logic       halted,
  output logic [5:0] t_state
);

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_t;

  logic [5:0] t_state_q, t_state_d;
  logic       halted_q, halted_d;
  logic       ring_ok;
  logic       last_state;
  logic       is_lda, is_add, is_sub, is_out, is_hlt, is_nop;
  ctrl_t      ctrl;

  assign is_lda = (opcode == OP_LDA);
  assign is_add = (opcode == OP_ADD);
  assign is_sub = (opcode == OP_SUB);
  assign is_out = (opcode == OP_OUT);
  assign is_hlt = (opcode == OP_HLT);
  assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);

  // Exactly one bit set: nonzero and no second bit.
  assign ring_ok = (t_state_q != 6'b0) && ((t_state_q & (t_state_q - 6'd1)) == 6'b0);

`ifdef SHORT_CYCLE_EN
  always_comb begin
    last_state = 1'b0;
    if (t_state_q == T6) last_state = 1'b1;
    else if (t_state_q == T5 && is_lda) last_state = 1'b1;
    else if (t_state_q == T4 && (is_out || is_nop)) last_state = 1'b1;
  end
`else
  assign last_state = (t_state_q == T6);
`endif

  always_comb begin
    t_state_d = t_state_q;
    halted_d  = halted_q;
    if (!ring_ok) begin
      t_state_d = T1;
    end else if (!halted_q) begin
      if (t_state_q == T4 && is_hlt) halted_d = 1'b1;
      else if (last_state)           t_state_d = T1;
      else                           t_state_d = {t_state_q[4:0], t_state_q[5]};
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      t_state_q <= T1;
      halted_q  <= 1'b0;
    end else begin
      t_state_q <= t_state_d;
      halted_q  <= halted_d;
    end
  end

  // Decode: non-one-hot ring values fall to the all-zero default.
  always_comb begin
    ctrl = '0;
    if (!halted_q) begin
      case (t_state_q)
        T1: begin ctrl.ep = 1'b1; ctrl.lm = 1'b1; end
        T2: ctrl.cp = 1'b1;
        T3: begin ctrl.ce = 1'b1; ctrl.li = 1'b1; end
        T4: begin
          if (is_lda || is_add || is_sub) begin
            ctrl.ei = 1'b1;
            ctrl.lm = 1'b1;
          end else if (is_out) begin
            ctrl.ea = 1'b1;
            ctrl.lo = 1'b1;
          end
        end
        T5: begin
          if (is_lda) begin
            ctrl.ce = 1'b1;
            ctrl.la = 1'b1;
          end else if (is_add || is_sub) begin
            ctrl.ce = 1'b1;
            ctrl.lb = 1'b1;
          end
        end
        T6: begin
          if (is_add || is_sub) begin
            ctrl.eu = 1'b1;
            ctrl.la = 1'b1;
            ctrl.su = is_sub;
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign pc_increment = ctrl.cp;
  assign pc_output    = ctrl.ep;
  assign mar_load     = ctrl.lm;
  assign ram_output   = ctrl.ce;
  assign ir_load      = ctrl.li;
  assign ir_output    = ctrl.ei;
  assign a_load       = ctrl.la;
  assign a_output     = ctrl.ea;
  assign alu_subtract = ctrl.su;
  assign alu_output   = ctrl.eu;
  assign b_load       = ctrl.lb;
  assign out_load     = ctrl.lo;
  assign halted       = halted_q;
  assign t_state      = t_state_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: stimulus queues expected per-cycle outputs, monitor compares on negedge.
module tb_controller_sequencer;

  localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
  localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
  localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

  localparam logic [5:0] T1 = 6'b000001, T2 = 6'b000010, T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000, T5 = 6'b010000, T6 = 6'b100000;

  logic       clk = 1'b0;
  logic       Clear;
  logic [3:0] opcode;
  logic       pc_increment, pc_output, mar_load, ram_output, ir_load, ir_output;
  logic       a_load, a_output, alu_subtract, alu_output, b_load, out_load, halted;
  logic [5:0] t_state;

  typedef struct {
    bit         chk;
    logic [5:0] t;
    logic       h;
    logic [11:0] cw;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  controller_sequencer dut (
    .Clock(clk), .Clear(Clear), .opcode(opcode),
    .pc_increment(pc_increment), .pc_output(pc_output), .mar_load(mar_load),
    .ram_output(ram_output), .ir_load(ir_load), .ir_output(ir_output),
    .a_load(a_load), .a_output(a_output), .alu_subtract(alu_subtract),
    .alu_output(alu_output), .b_load(b_load), .out_load(out_load),
    .halted(halted), .t_state(t_state)
  );

  always #5 clk = ~clk;

  wire [11:0] cw_act = {pc_increment, pc_output, mar_load, ram_output, ir_load, ir_output,
                        a_load, a_output, alu_subtract, alu_output, b_load, out_load};

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        checks++;
        if (t_state !== e.t) begin
          errors++;
          $display("FAIL %s t_state: got %b expected %b", e.nm, t_state, e.t);
        end
        checks++;
        if (halted !== e.h) begin
          errors++;
          $display("FAIL %s halted: got %b expected %b", e.nm, halted, e.h);
        end
        checks++;
        if (cw_act !== e.cw) begin
          errors++;
          $display("FAIL %s ctrl: got %h expected %h", e.nm, cw_act, e.cw);
        end
      end
    end
  end

  task automatic step(input logic clr, input logic [3:0] op, input logic [5:0] t,
                      input logic h, input logic [11:0] cw, input bit chk, input string nm);
    exp_t e;
    Clear  = clr;
    opcode = op;
    e.chk = chk; e.t = t; e.h = h; e.cw = cw; e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] op, input string nm);
    step(1'b0, op, T1, 1'b0, EP | LM, 1'b1, {nm, "_T1"});
    step(1'b0, op, T2, 1'b0, CP,      1'b1, {nm, "_T2"});
    step(1'b0, op, T3, 1'b0, CE | LI, 1'b1, {nm, "_T3"});
  endtask

  initial begin
    Clear  = 1'b1;
    opcode = 4'h0;
    @(posedge clk);
    #1;
    step(1'b1, 4'h0, T1, 1'b0, EP | LM, 1'b0, "clr");

    // LDA
    fetch(4'h0, "lda");
    step(1'b0, 4'h0, T4, 1'b0, EI | LM, 1'b1, "lda_T4");
    step(1'b0, 4'h0, T5, 1'b0, CE | LA, 1'b1, "lda_T5");
`ifndef SHORT_CYCLE_EN
    step(1'b0, 4'h0, T6, 1'b0, NONE,    1'b1, "lda_T6");
`endif

    // ADD
    fetch(4'h1, "add");
    step(1'b0, 4'h1, T4, 1'b0, EI | LM,   1'b1, "add_T4");
    step(1'b0, 4'h1, T5, 1'b0, CE | LB,   1'b1, "add_T5");
    step(1'b0, 4'h1, T6, 1'b0, EU | LA,   1'b1, "add_T6");

    // SUB
    fetch(4'h2, "sub");
    step(1'b0, 4'h2, T4, 1'b0, EI | LM,      1'b1, "sub_T4");
    step(1'b0, 4'h2, T5, 1'b0, CE | LB,      1'b1, "sub_T5");
    step(1'b0, 4'h2, T6, 1'b0, EU | LA | SU, 1'b1, "sub_T6");

    // OUT
    fetch(4'hE, "out");
    step(1'b0, 4'hE, T4, 1'b0, EA | LO, 1'b1, "out_T4");
`ifndef SHORT_CYCLE_EN
    step(1'b0, 4'hE, T5, 1'b0, NONE,    1'b1, "out_T5");
    step(1'b0, 4'hE, T6, 1'b0, NONE,    1'b1, "out_T6");
`endif

    // Undefined opcode behaves as NOP
    fetch(4'h7, "nop");
    step(1'b0, 4'h7, T4, 1'b0, NONE, 1'b1, "nop_T4");
`ifndef SHORT_CYCLE_EN
    step(1'b0, 4'h7, T5, 1'b0, NONE, 1'b1, "nop_T5");
    step(1'b0, 4'h7, T6, 1'b0, NONE, 1'b1, "nop_T6");
`endif

    // Clear mid-T5 of ADD
    fetch(4'h1, "clradd");
    step(1'b0, 4'h1, T4, 1'b0, EI | LM, 1'b1, "clradd_T4");
    step(1'b1, 4'h1, T5, 1'b0, CE | LB, 1'b1, "clradd_T5");
    step(1'b0, 4'h1, T1, 1'b0, EP | LM, 1'b1, "after_clr_T1");
    step(1'b0, 4'h1, T2, 1'b0, CP,      1'b1, "after_clr_T2");
    step(1'b0, 4'h1, T3, 1'b0, CE | LI, 1'b1, "after_clr_T3");
    step(1'b0, 4'h1, T4, 1'b0, EI | LM, 1'b1, "after_clr_T4");
    step(1'b0, 4'h1, T5, 1'b0, CE | LB, 1'b1, "after_clr_T5");
    step(1'b0, 4'h1, T6, 1'b0, EU | LA, 1'b1, "after_clr_T6");

    // HLT freezes in T4 until Clear
    fetch(4'hF, "hlt");
    step(1'b0, 4'hF, T4, 1'b0, NONE, 1'b1, "hlt_T4");
    for (int i = 0; i < 20; i++)
      step(1'b0, (i % 2 == 0) ? 4'hF : 4'h1, T4, 1'b1, NONE, 1'b1, "halted");
    step(1'b1, 4'h0, T4, 1'b1, NONE, 1'b1, "halted_clr");
    fetch(4'h0, "restart");
    step(1'b0, 4'h0, T4, 1'b0, EI | LM, 1'b1, "restart_T4");

    @(negedge clk);
    @(negedge clk);
    stim_done = 1'b1;
  end

  initial begin
    fork
      wait (stim_done);
      begin
        repeat (2000) @(posedge clk);
        checks++;
        errors++;
        $display("FAIL watchdog: stimulus did not complete, got timeout expected completion");
      end
    join_any
    disable fork;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
